// File: rtl/sam_seq_ctrl.sv
// sam_seq_ctrl: sequential signed multiplier controller.
// Shift-and-accumulate over operand magnitudes, one multiplier bit per clock,
// with the sign applied in a single final step. Latency is fixed at WIDTH+2
// edges from accept to the done cycle, regardless of operand values.
module sam_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] addend;

    // Operand magnitudes and the shifted partial product for this iteration.
    // Negating -2^(W-1) wraps back to the same bit pattern, which read as
    // unsigned is exactly 2^(W-1), so no extra bit is needed.
    always_comb begin
        a_mag  = a[WIDTH-1] ? -a : a;
        b_mag  = b[WIDTH-1] ? -b : b;
        addend = {{WIDTH{1'b0}}, mcand_q} << count_q;
    end

    // Next-state and next-output logic; outputs are registered alongside state.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        count_d  = count_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = CALC;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    state_d  = IDLE;
                    ready_d  = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            CALC: begin
                // Always runs all WIDTH iterations so latency never depends on data.
                if (mplier_q[0]) begin
                    acc_d = acc_q + addend;
                end
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_ONE;
                if (count_q == CNT_LAST) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                // A zero magnitude negates to zero, so neg needs no special case.
                result_d = neg_q ? -acc_q : acc_q;
                done_d   = 1'b1;
                state_d  = DONE;
                ready_d  = 1'b1;
                busy_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
